// File: rtl/wordle_pkg.sv
// Shared constants, row types and controller state encoding for the wordle board.
package wordle_pkg;
    localparam int CELL_W = 7;
    localparam int ROW_W  = 35;
    localparam int ROWS   = 6;
    localparam int COLS   = 5;

    localparam logic [1:0] COLOR_GRAY   = 2'd0;
    localparam logic [1:0] COLOR_GREEN  = 2'd1;
    localparam logic [1:0] COLOR_YELLOW = 2'd2;
    localparam logic [1:0] COLOR_RED    = 2'd3;

    localparam logic [4:0] LTR_BLANK = 5'd26;

    localparam logic [1:0] KEY_LETTER = 2'd0;
    localparam logic [1:0] KEY_BACK   = 2'd1;
    localparam logic [1:0] KEY_ENTER  = 2'd2;

    typedef enum logic [2:0] {ENTRY, GREEN, YELLOW, COMMIT, WON, LOST, FLASH} state_e;

    typedef logic [COLS-1:0][4:0] row_ltr_t;
    typedef logic [COLS-1:0][1:0] row_col_t;
endpackage

// File: rtl/wordle_board_ctrl_if.sv
// Keystroke handshake between the keyboard front end (master) and the board controller (slave).
interface wordle_board_ctrl_if;
    logic       key_valid;
    logic       key_ready;
    logic [1:0] key_type;
    logic [4:0] key_letter;

    modport master (output key_valid, key_type, key_letter, input key_ready);
    modport slave  (input key_valid, key_type, key_letter, output key_ready);
endinterface

// File: rtl/wordle_row_scorer.sv
// Scores one guess row: one cycle of exact matches, then one cycle per column for
// misplaced letters, consuming each target letter at most once.
module wordle_row_scorer import wordle_pkg::*; (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [24:0] guess,
    input  logic [24:0] target,
    output logic [9:0]  colors,
    output logic        done
);
    typedef enum logic [1:0] {SC_IDLE, SC_GREEN, SC_YEL} sc_e;

    sc_e             phase_q, phase_d;
    row_ltr_t        guess_q, guess_d, target_q, target_d;
    row_col_t        colors_q, colors_d;
    logic [COLS-1:0] used_q, used_d, green;
    logic [2:0]      idx_q, idx_d;
    logic            done_q, done_d;
    logic            hit;
    logic [2:0]      hit_j;

    always_comb begin
        for (int i = 0; i < COLS; i++) green[i] = (guess_q[i] == target_q[i]);
    end

    // Descending scan so the lowest matching unused target column wins.
    always_comb begin
        hit   = 1'b0;
        hit_j = '0;
        for (int j = COLS-1; j >= 0; j--) begin
            if (!used_q[j] && target_q[j] == guess_q[idx_q]) begin
                hit   = 1'b1;
                hit_j = 3'(j);
            end
        end
    end

    always_comb begin
        phase_d  = phase_q;
        guess_d  = guess_q;
        target_d = target_q;
        colors_d = colors_q;
        used_d   = used_q;
        idx_d    = idx_q;
        done_d   = 1'b0;
        case (phase_q)
            SC_IDLE: if (start) begin
                guess_d  = guess;
                target_d = target;
                phase_d  = SC_GREEN;
            end
            SC_GREEN: begin
                used_d  = green;
                idx_d   = '0;
                phase_d = SC_YEL;
                for (int i = 0; i < COLS; i++) colors_d[i] = green[i] ? COLOR_GREEN : COLOR_GRAY;
            end
            SC_YEL: begin
                if (!green[idx_q] && hit) begin
                    used_d[hit_j]   = 1'b1;
                    colors_d[idx_q] = COLOR_YELLOW;
                end
                if (idx_q == 3'(COLS-1)) begin
                    phase_d = SC_IDLE;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            default: phase_d = SC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q  <= SC_IDLE;
            guess_q  <= '0;
            target_q <= '0;
            colors_q <= '0;
            used_q   <= '0;
            idx_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            guess_q  <= guess_d;
            target_q <= target_d;
            colors_q <= colors_d;
            used_q   <= used_d;
            idx_q    <= idx_d;
            done_q   <= done_d;
        end
    end

    assign colors = colors_q;
    assign done   = done_q;
endmodule

// File: rtl/wordle_board_ctrl.sv
// Wordle board controller: key entry into the 6x5 grid, row scoring, win/loss tracking.
// Define WORDLE_REJECT_FLASH_EN to flash the row dark red on an enter with a partial row.
module wordle_board_ctrl import wordle_pkg::*; #(
    parameter int FLASH_CYCLES = 12_500_000
) (
    input  logic                dclk,
    input  logic                clr,
    input  logic                new_game,
    input  logic [24:0]         target_word,
    wordle_board_ctrl_if.slave  kif,
    output logic [209:0]        display,
    output logic [2:0]          cur_row,
    output logic [2:0]          cur_col,
    output logic                game_won,
    output logic                game_lost
);
    state_e                          state_q, state_d;
    logic [ROWS-1:0][COLS-1:0][4:0]  ltr_q, ltr_d;
    logic [ROWS-1:0][COLS-1:0][1:0]  col_q, col_d;
    logic [2:0]                      cur_row_q, cur_row_d, cur_col_q, cur_col_d;
    logic                            won_q, won_d, lost_q, lost_d;
    logic [24:0]                     target_q, target_d;
    logic [2:0]                      ycnt_q, ycnt_d;
    logic                            accept, score_start, score_rst, score_done;
    logic [9:0]                      score_colors;
    logic [ROWS-1:0]                 flash_row;

`ifdef WORDLE_REJECT_FLASH_EN
    localparam int FW = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
    logic [FW-1:0] fcnt_q, fcnt_d;

    always_comb begin
        for (int r = 0; r < ROWS; r++) flash_row[r] = (state_q == FLASH) && (cur_row_q == 3'(r));
    end
`else
    logic unused_flash;
    assign unused_flash = (FLASH_CYCLES != 0);
    assign flash_row    = '0;
`endif

    assign kif.key_ready = (state_q == ENTRY);
    assign accept        = kif.key_valid && (state_q == ENTRY);
    assign score_start   = accept && !new_game && kif.key_type == KEY_ENTER && cur_col_q == 3'(COLS);
    // Any restart also aborts an in-flight score so no partial colors survive.
    assign score_rst     = clr || new_game;

    wordle_row_scorer u_scorer (
        .clk    (dclk),
        .rst    (score_rst),
        .start  (score_start),
        .guess  (ltr_q[cur_row_q]),
        .target (target_q),
        .colors (score_colors),
        .done   (score_done)
    );

    always_comb begin
        state_d   = state_q;
        ltr_d     = ltr_q;
        col_d     = col_q;
        cur_row_d = cur_row_q;
        cur_col_d = cur_col_q;
        won_d     = won_q;
        lost_d    = lost_q;
        target_d  = target_q;
        ycnt_d    = ycnt_q;
`ifdef WORDLE_REJECT_FLASH_EN
        fcnt_d    = fcnt_q;
`endif
        if (new_game) begin
            state_d   = ENTRY;
            ltr_d     = {(ROWS*COLS){LTR_BLANK}};
            col_d     = '0;
            cur_row_d = '0;
            cur_col_d = '0;
            won_d     = 1'b0;
            lost_d    = 1'b0;
            target_d  = target_word;
            ycnt_d    = '0;
        end else begin
            case (state_q)
                ENTRY: if (accept) begin
                    case (kif.key_type)
                        KEY_LETTER: if (cur_col_q < 3'(COLS)) begin
                            ltr_d[cur_row_q][cur_col_q] = kif.key_letter;
                            cur_col_d = cur_col_q + 3'd1;
                        end
                        KEY_BACK: if (cur_col_q != 3'd0) begin
                            ltr_d[cur_row_q][cur_col_q - 3'd1] = LTR_BLANK;
                            cur_col_d = cur_col_q - 3'd1;
                        end
                        KEY_ENTER: begin
                            if (cur_col_q == 3'(COLS)) state_d = GREEN;
`ifdef WORDLE_REJECT_FLASH_EN
                            else begin
                                state_d = FLASH;
                                fcnt_d  = '0;
                            end
`endif
                        end
                        default: ;
                    endcase
                end
                GREEN: begin
                    state_d = YELLOW;
                    ycnt_d  = '0;
                end
                YELLOW: begin
                    if (ycnt_q == 3'(COLS-1)) state_d = COMMIT;
                    else                      ycnt_d  = ycnt_q + 3'd1;
                end
                COMMIT: if (score_done) begin
                    col_d[cur_row_q] = score_colors;
                    if (score_colors == {COLS{COLOR_GREEN}}) begin
                        state_d = WON;
                        won_d   = 1'b1;
                    end else if (cur_row_q == 3'(ROWS-1)) begin
                        state_d = LOST;
                        lost_d  = 1'b1;
                    end else begin
                        state_d   = ENTRY;
                        cur_row_d = cur_row_q + 3'd1;
                        cur_col_d = '0;
                    end
                end
                FLASH: begin
`ifdef WORDLE_REJECT_FLASH_EN
                    if (fcnt_q == FW'(FLASH_CYCLES-1)) state_d = ENTRY;
                    else                               fcnt_d  = fcnt_q + FW'(1);
`else
                    state_d = ENTRY;
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge dclk) begin
        if (clr) begin
            state_q   <= ENTRY;
            ltr_q     <= {(ROWS*COLS){LTR_BLANK}};
            col_q     <= '0;
            cur_row_q <= '0;
            cur_col_q <= '0;
            won_q     <= 1'b0;
            lost_q    <= 1'b0;
            target_q  <= target_word;
            ycnt_q    <= '0;
`ifdef WORDLE_REJECT_FLASH_EN
            fcnt_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ltr_q     <= ltr_d;
            col_q     <= col_d;
            cur_row_q <= cur_row_d;
            cur_col_q <= cur_col_d;
            won_q     <= won_d;
            lost_q    <= lost_d;
            target_q  <= target_d;
            ycnt_q    <= ycnt_d;
`ifdef WORDLE_REJECT_FLASH_EN
            fcnt_q    <= fcnt_d;
`endif
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            assign display[ROW_W*r + CELL_W*c +: CELL_W] =
                {flash_row[r] ? COLOR_RED : col_q[r][c], ltr_q[r][c]};
        end
    end

    assign cur_row   = cur_row_q;
    assign cur_col   = cur_col_q;
    assign game_won  = won_q;
    assign game_lost = lost_q;
endmodule

// File: tb/tb_wordle_board_ctrl.sv
// Directed bench for wordle_board_ctrl; the reject-flash steps run only when
// WORDLE_REJECT_FLASH_EN is defined (FLASH_CYCLES is set to 4 here).
module tb_wordle_board_ctrl;
    logic         dclk = 1'b0;
    logic         clr;
    logic         new_game;
    logic [24:0]  target_word;
    logic [209:0] display;
    logic [2:0]   cur_row, cur_col;
    logic         game_won, game_lost;
    int           n_cmp = 0;
    int           n_err = 0;
    logic [209:0] blank_disp;

    wordle_board_ctrl_if kif();

    wordle_board_ctrl #(.FLASH_CYCLES(4)) dut (
        .dclk        (dclk),
        .clr         (clr),
        .new_game    (new_game),
        .target_word (target_word),
        .kif         (kif),
        .display     (display),
        .cur_row     (cur_row),
        .cur_col     (cur_col),
        .game_won    (game_won),
        .game_lost   (game_lost)
    );

    always #5 dclk = ~dclk;

    function automatic logic [4:0] lc(input byte ch);
        return 5'(ch - 8'd65);
    endfunction

    function automatic logic [24:0] w(input string s);
        logic [24:0] v = '0;
        for (int i = 0; i < 5; i++) v[5*i +: 5] = lc(s[i]);
        return v;
    endfunction

    function automatic logic [9:0] cv(input int c0, c1, c2, c3, c4);
        return {c4[1:0], c3[1:0], c2[1:0], c1[1:0], c0[1:0]};
    endfunction

    function automatic logic [9:0] row_colors(input logic [209:0] d, input int r);
        logic [9:0] v = '0;
        for (int c = 0; c < 5; c++) v[2*c +: 2] = d[35*r + 7*c + 5 +: 2];
        return v;
    endfunction

    function automatic logic [24:0] row_letters(input logic [209:0] d, input int r);
        logic [24:0] v = '0;
        for (int c = 0; c < 5; c++) v[5*c +: 5] = d[35*r + 7*c +: 5];
        return v;
    endfunction

    task automatic chk(input string tag, input logic [209:0] obs, input logic [209:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge dclk);
        #1;
    endtask

    task automatic press(input logic [1:0] t, input logic [4:0] l);
        kif.key_valid  = 1'b1;
        kif.key_type   = t;
        kif.key_letter = l;
        tick();
        kif.key_valid  = 1'b0;
    endtask

    task automatic type_word(input string s);
        for (int i = 0; i < 5; i++) press(2'd0, lc(s[i]));
    endtask

    task automatic start_game(input string s);
        target_word = w(s);
        new_game    = 1'b1;
        tick();
        new_game    = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 30; k++) blank_disp[7*k +: 7] = 7'd26;
        kif.key_valid  = 1'b0;
        kif.key_type   = 2'd0;
        kif.key_letter = 5'd0;
        new_game       = 1'b0;
        clr            = 1'b1;
        target_word    = w("CRANE");
        repeat (2) @(posedge dclk);
        #1;
        clr = 1'b0;

        chk("reset_display", display, blank_disp);
        chk("reset_row", 210'(cur_row), 210'(0));
        chk("reset_col", 210'(cur_col), 210'(0));
        chk("reset_won_lost", 210'({game_won, game_lost}), 210'(0));
        chk("reset_ready", 210'(kif.key_ready), 210'(1));

        // CRANE vs CRANE: win after 7 edges
        type_word("CRANE");
        chk("crane_col_full", 210'(cur_col), 210'(5));
        press(2'd2, 5'd0);
        chk("crane_busy_ready", 210'(kif.key_ready), 210'(0));
        repeat (6) tick();
        chk("crane_precommit", 210'(row_colors(display, 0)), 210'(0));
        chk("crane_precommit_won", 210'(game_won), 210'(0));
        tick();
        chk("crane_colors", 210'(row_colors(display, 0)), 210'(cv(1,1,1,1,1)));
        chk("crane_letters", 210'(row_letters(display, 0)), 210'(w("CRANE")));
        chk("crane_won", 210'(game_won), 210'(1));
        chk("crane_ready", 210'(kif.key_ready), 210'(0));
        press(2'd0, 5'd3);
        chk("won_frozen_row1", 210'(row_letters(display, 1)), 210'({5{5'd26}}));

        // ABBEY vs BABES
        start_game("ABBEY");
        chk("ng_display", display, blank_disp);
        chk("ng_won", 210'(game_won), 210'(0));
        type_word("BABES");
        press(2'd2, 5'd0);
        repeat (7) tick();
        chk("babes_colors", 210'(row_colors(display, 0)), 210'(cv(2,2,1,1,0)));
        chk("babes_row", 210'(cur_row), 210'(1));
        chk("babes_col", 210'(cur_col), 210'(0));
        chk("babes_ready", 210'(kif.key_ready), 210'(1));

        // backspace underflow and short enter
        press(2'd0, lc("A"));
        press(2'd0, lc("B"));
        press(2'd1, 5'd0);
        chk("bs_one_col", 210'(cur_col), 210'(1));
        press(2'd1, 5'd0);
        press(2'd1, 5'd0);
        chk("bs_col_zero", 210'(cur_col), 210'(0));
        chk("bs_row_blank", 210'(row_letters(display, 1)), 210'({5{5'd26}}));
        press(2'd2, 5'd0);
        chk("short_enter_ready", 210'(kif.key_ready), 210'(1));
        chk("short_enter_col", 210'(cur_col), 210'(0));

        // ALLOT vs LLAMA, plus sixth letter on a full row
        start_game("ALLOT");
        type_word("LLAMA");
        press(2'd0, lc("Z"));
        chk("full_row_col", 210'(cur_col), 210'(5));
        chk("full_row_letters", 210'(row_letters(display, 0)), 210'(w("LLAMA")));
        press(2'd2, 5'd0);
        repeat (7) tick();
        chk("llama_colors", 210'(row_colors(display, 0)), 210'(cv(2,1,2,0,0)));

        // six wrong guesses lose
        start_game("CRANE");
        for (int g = 0; g < 6; g++) begin
            type_word("ENARC");
            press(2'd2, 5'd0);
            repeat (7) tick();
        end
        chk("loss_lost", 210'(game_lost), 210'(1));
        chk("loss_won", 210'(game_won), 210'(0));
        chk("loss_row", 210'(cur_row), 210'(5));
        chk("loss_ready", 210'(kif.key_ready), 210'(0));
        chk("loss_row5_colors", 210'(row_colors(display, 5)), 210'(cv(2,2,1,2,2)));

        // new_game with a concurrent key: key discarded
        start_game("CRANE");
        kif.key_valid  = 1'b1;
        kif.key_type   = 2'd0;
        kif.key_letter = lc("Q");
        new_game       = 1'b1;
        tick();
        new_game       = 1'b0;
        kif.key_valid  = 1'b0;
        chk("ng_key_col", 210'(cur_col), 210'(0));
        chk("ng_key_letters", 210'(row_letters(display, 0)), 210'({5{5'd26}}));

        // new_game mid-YELLOW aborts scoring
        type_word("CRANE");
        press(2'd2, 5'd0);
        repeat (3) tick();
        start_game("ABBEY");
        repeat (6) tick();
        chk("abort_ng_display", display, blank_disp);
        chk("abort_ng_row", 210'(cur_row), 210'(0));
        chk("abort_ng_won", 210'(game_won), 210'(0));
        chk("abort_ng_ready", 210'(kif.key_ready), 210'(1));

        // clr mid-score aborts and re-latches the target
        type_word("ABBEY");
        press(2'd2, 5'd0);
        repeat (2) tick();
        clr         = 1'b1;
        target_word = w("CRANE");
        tick();
        clr         = 1'b0;
        repeat (6) tick();
        chk("abort_clr_display", display, blank_disp);
        chk("abort_clr_won", 210'(game_won), 210'(0));
        type_word("CRANE");
        press(2'd2, 5'd0);
        repeat (7) tick();
        chk("clr_target_won", 210'(game_won), 210'(1));

`ifdef WORDLE_REJECT_FLASH_EN
        start_game("CRANE");
        press(2'd0, lc("C"));
        press(2'd0, lc("R"));
        press(2'd0, lc("A"));
        press(2'd2, 5'd0);
        for (int k = 0; k < 4; k++) begin
            chk("flash_colors", 210'(row_colors(display, 0)), 210'(cv(3,3,3,3,3)));
            chk("flash_ready", 210'(kif.key_ready), 210'(0));
            tick();
        end
        chk("flash_restore", 210'(row_colors(display, 0)), 210'(0));
        chk("flash_ready_back", 210'(kif.key_ready), 210'(1));
        chk("flash_col", 210'(cur_col), 210'(3));
        chk("flash_row1", 210'(row_colors(display, 1)), 210'(0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
